// File: rtl/x_multdiv.sv
// Multicycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Captures operands on a start pulse, iterates, then presents a registered result with a one-cycle RDY pulse.
module x_multdiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH / 2);
    localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } stateT;

    stateT state, stateNxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;      // multiplicand
    logic [WIDTH-1:0] divisor;    // divisor magnitude
    logic [WIDTH-1:0] prodHi;     // upper half of Booth product
    logic [WIDTH-1:0] lowReg;     // multiplier/product low half, or dividend/quotient
    logic             qm1;        // Booth guard bit below lowReg[0]
    logic [WIDTH+1:0] rem;        // signed partial remainder
    logic             negQ, divZero, divOvf;

    logic             startMul, startDiv, start;
    logic             finish;
    logic [WIDTH-1:0] resultNxt;
    logic             excNxt;
    logic [WIDTH-1:0] absA, absB;

    logic [WIDTH+1:0] mcandExt, ppAdd, boothSum;
    logic [WIDTH+1:0] remShift, remStep;
    logic             quoBit;

    // MULT has priority over a simultaneous DIV
    assign startMul = ctrl_MULT;
    assign startDiv = ctrl_DIV & ~ctrl_MULT;
    assign start    = startMul | startDiv;

    assign absA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign absB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Radix-4 Booth recode of {lowReg[1:0], qm1} and accumulate into the upper half
    always_comb begin
        mcandExt = {{2{mcand[WIDTH-1]}}, mcand};
        ppAdd    = '0;
        case ({lowReg[1:0], qm1})
            3'b001, 3'b010: ppAdd = mcandExt;
            3'b011:         ppAdd = mcandExt << 1;
            3'b100:         ppAdd = -(mcandExt << 1);
            3'b101, 3'b110: ppAdd = -mcandExt;
            default:        ppAdd = '0;
        endcase
        boothSum = {{2{prodHi[WIDTH-1]}}, prodHi} + ppAdd;
    end

    // Non-restoring step: add or subtract divisor depending on remainder sign
    always_comb begin
        remShift = {rem[WIDTH:0], lowReg[WIDTH-1]};
        remStep  = rem[WIDTH+1] ? remShift + {2'b00, divisor}
                                : remShift - {2'b00, divisor};
        quoBit   = ~remStep[WIDTH+1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNxt;
    end

    always_comb begin
        stateNxt  = state;
        finish    = 1'b0;
        resultNxt = '0;
        excNxt    = 1'b0;
        case (state)
            IDLE: ;
            MUL, DIV: begin
                if (cnt == '0) begin
                    finish   = 1'b1;
                    stateNxt = DONE;
                end
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
        if (startMul)      stateNxt = MUL;
        else if (startDiv) stateNxt = DIV;

        if (state == MUL) begin
            resultNxt = lowReg;
            excNxt    = (prodHi != {WIDTH{lowReg[WIDTH-1]}});
        end else begin
            resultNxt = divZero ? '0 : (negQ ? -lowReg : lowReg);
            excNxt    = divZero | divOvf;
        end
    end

    // Operand capture and per-clock iteration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            mcand   <= '0;
            divisor <= '0;
            prodHi  <= '0;
            lowReg  <= '0;
            qm1     <= 1'b0;
            rem     <= '0;
            negQ    <= 1'b0;
            divZero <= 1'b0;
            divOvf  <= 1'b0;
        end else if (start) begin
            cnt     <= startMul ? MUL_ITERS : DIV_ITERS;
            mcand   <= data_operandA;
            divisor <= absB;
            prodHi  <= '0;
            lowReg  <= startMul ? data_operandB : absA;
            qm1     <= 1'b0;
            rem     <= '0;
            negQ    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            divZero <= (data_operandB == '0);
            divOvf  <= (data_operandA == MOST_NEG) && (data_operandB == '1);
        end else if ((state == MUL || state == DIV) && cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (state == MUL) begin
                prodHi <= boothSum[WIDTH+1:2];
                lowReg <= {boothSum[1:0], lowReg[WIDTH-1:2]};
                qm1    <= lowReg[1];
            end else begin
                rem    <= remStep;
                lowReg <= {lowReg[WIDTH-2:0], quoBit};
            end
        end
    end

    // Registered outputs; result/exception only move on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= finish;
            busy           <= (stateNxt == MUL) || (stateNxt == DIV);
            if (finish) begin
                data_result    <= resultNxt;
                data_exception <= excNxt;
            end
        end
    end

endmodule

// File: tb/tb_x_multdiv.sv
// Scoreboard bench for x_multdiv: expected results queued at start, checked every cycle
// against RDY timing, held result/exception and busy.
module tb_x_multdiv;

    logic        clk;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    x_multdiv #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned due;
    } sbEntry;

    sbEntry      sb[$];
    int unsigned cyc = 0;
    int          nChecks = 0;
    int          nFails = 0;
    logic [31:0] lastRes = '0;
    logic        lastExc = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [32:0] refMul(input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] pv;
        logic [31:0] lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        pv = p;
        lo = pv[31:0];
        return {(p != longint'($signed(lo))), lo};
    endfunction

    function automatic logic [32:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        longint      q;
        logic [63:0] qv;
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q  = longint'($signed(a)) / longint'($signed(b));
        qv = q;
        return {1'b0, qv[31:0]};
    endfunction

    task automatic monitor();
        logic   expRdy, expBusy;
        sbEntry e;
        expRdy = (sb.size() > 0) && (sb[0].due == cyc);
        check("rdy", data_resultRDY, expRdy);
        if (expRdy) begin
            e       = sb.pop_front();
            lastRes = e.res;
            lastExc = e.exc;
        end
        check("result", data_result, lastRes);
        check("exception", data_exception, lastExc);
        expBusy = 1'b0;
        foreach (sb[i]) if (sb[i].due > cyc) expBusy = 1'b1;
        check("busy", busy, expBusy);
    endtask

    // One clock: sample 2 units after the rising edge, return at the falling edge
    task automatic step();
        @(posedge clk);
        cyc++;
        #2;
        monitor();
        @(negedge clk);
    endtask

    // Start held for n edges; each edge aborts anything not finishing on that edge
    task automatic launch(input logic mul, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        sbEntry e;
        for (int k = 0; k < n; k++) begin
            data_operandA = a;
            data_operandB = b;
            ctrl_MULT     = mul;
            ctrl_DIV      = dv;
            while (sb.size() > 0 && sb[$].due > cyc + 1) void'(sb.pop_back());
            e.due = cyc + 1 + (mul ? 17 : 33);
            {e.exc, e.res} = mul ? refMul(a, b) : refDiv(a, b);
            sb.push_back(e);
            step();
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic waitDone();
        for (int k = 0; k < 80 && sb.size() > 0; k++) step();
        if (sb.size() > 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        step();
        step();
    endtask

    task automatic runOp(input logic mul, input logic [31:0] a, input logic [31:0] b);
        launch(mul, ~mul, a, b, 1);
        waitDone();
    endtask

    int unsigned d;
    logic [31:0] ra, rb;

    initial begin
        reset         = 1'b1;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exception", data_exception, 1'b0);
        check("reset rdy", data_resultRDY, 1'b0);
        check("reset busy", busy, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();

        // directed multiply / divide cases
        runOp(1'b1, 32'd7, 32'hFFFF_FFFD);
        runOp(1'b1, 32'h0001_0000, 32'h0001_0000);
        runOp(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(1'b1, 32'h8000_0000, 32'h8000_0000);
        runOp(1'b0, 32'hFFFF_FFF9, 32'd2);
        runOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(1'b0, 32'd5, 32'd0);
        runOp(1'b0, 32'h8000_0000, 32'd1);
        runOp(1'b0, 32'd7, 32'h8000_0000);
        runOp(1'b0, 32'h8000_0000, 32'h8000_0000);
        runOp(1'b0, 32'd100, 32'hFFFF_FFF9);

        // restart: DIV aborted by MULT on E10; old E33 must stay quiet
        launch(1'b0, 1'b1, 32'd100, 32'd7, 1);
        for (int k = 0; k < 9; k++) step();
        launch(1'b1, 1'b0, 32'd6, 32'd7, 1);
        waitDone();
        for (int k = 0; k < 12; k++) step();

        // simultaneous start: MULT wins
        launch(1'b1, 1'b1, 32'd6, 32'd3, 1);
        waitDone();

        // start sampled on the RDY edge
        launch(1'b1, 1'b0, 32'd123, 32'd456, 1);
        d = sb[$].due;
        while (cyc + 1 < d) step();
        launch(1'b0, 1'b1, 32'hFFFF_FC18, 32'd9, 1);
        waitDone();

        // back-to-back start in the RDY cycle
        launch(1'b0, 1'b1, 32'd1000, 32'd3, 1);
        d = sb[$].due;
        while (cyc < d) step();
        launch(1'b1, 1'b0, 32'hFFFF_8000, 32'd3, 1);
        waitDone();

        // start held for three edges
        launch(1'b1, 1'b0, 32'd12345, 32'hFFFF_FD5A, 3);
        waitDone();

        // random operands
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
            runOp(1'b1, ra, rb);
        end
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
            runOp(1'b0, ra, rb);
        end

        // asynchronous reset in the middle of a multiply
        launch(1'b1, 1'b0, 32'd9, 32'd11, 1);
        for (int k = 0; k < 4; k++) step();
        #2;
        reset = 1'b1;
        sb.delete();
        lastRes = '0;
        lastExc = 1'b0;
        #1;
        check("async reset result", data_result, 32'd0);
        check("async reset exception", data_exception, 1'b0);
        check("async reset rdy", data_resultRDY, 1'b0);
        check("async reset busy", busy, 1'b0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 40; k++) step();

        runOp(1'b1, 32'hFFFF_FFF6, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/x_multdiv.md
# x_multdiv

Multicycle signed multiply/divide unit in the execute stage, directly upstream of the X/M pipeline latch. It captures two 32-bit operands on a one-cycle start pulse and iterates internally. It then presents a registered result and exception flag to the X/M latch's ALU-result and overflow inputs, with a one-cycle ready pulse. While an operation is in flight it asserts `busy`, which the hazard logic uses to stall the F/D and D/X latches.

## Interface
- `WIDTH`, 32, operand/result width; must be even. Multiply latency is WIDTH/2+1 clocks and divide latency is WIDTH+1 clocks.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `data_operandA`  in  WIDTH  multiplicand / dividend, two's complement
- `data_operandB`  in  WIDTH  multiplier / divisor, two's complement
- `ctrl_MULT`  in  1  start-multiply pulse, sampled on rising edge
- `ctrl_DIV`  in  1  start-divide pulse, sampled on rising edge
- `data_result`  out  WIDTH  registered result, held until the next start
- `data_exception`  out  1  overflow / divide-by-zero flag, held with `data_result`
- `data_resultRDY`  out  1  one-cycle pulse marking a valid new result
- `busy`  out  1  operation in progress

## Operation
- One clock; reset is asynchronous and active-high.
- **Reset values:** all outputs 0, state IDLE, counter 0. Reset mid-operation discards the operation; no RDY pulse follows.
- **States:**
  - IDLE: waits for a start pulse.
  - MUL: radix-4 modified Booth, one 2-bit recode per clock, WIDTH/2 iterations on a 2*WIDTH+1-bit product register.
  - DIV: non-restoring division on operand magnitudes, one quotient bit per clock, WIDTH iterations.
  - DONE: writes the result registers and pulses RDY, then returns to IDLE.
- **Start capture:** a start pulse seen on an edge captures both operands and loads the counter, from any state. A start during MUL, DIV or DONE aborts the current operation and restarts.
- **Simultaneous starts:** if `ctrl_MULT` and `ctrl_DIV` are both high, MULT wins.
- **Multiply result:**
  - `data_result` = low WIDTH bits of the signed product.
  - `data_exception` = 1 iff the full 2*WIDTH-bit product is not the sign extension of those low bits.
- **Divide result:**
  - Quotient is truncated toward zero; its sign is the XOR of the operand signs. The remainder is discarded.
  - Divisor 0: `data_result` = 0, `data_exception` = 1, at the normal divide latency.
  - Dividend = most-negative value and divisor = -1: `data_result` = most-negative value, `data_exception` = 1.
- **Output holding:** `data_result` and `data_exception` change only on entry to DONE or on reset. A start does not clear them.

## Timing
- **Capture edge:** E0 is the edge that samples a start pulse.
- **Multiply:**
  - Iterations run on edges E1..E(WIDTH/2).
  - At E(WIDTH/2+1) (E17 for WIDTH=32) the results are registered and RDY rises.
  - RDY falls at E(WIDTH/2+2).
- **Divide:** same pattern. Iterations on E1..E(WIDTH), results and RDY at E(WIDTH+1) (E33), RDY falls at E(WIDTH+2).
- **busy:** rises at E0 and falls at the same edge RDY rises. It is never high in the same cycle as RDY, except when a start is sampled on the RDY edge.
- **Start on the RDY edge:** the just-finished result and RDY are still delivered, and the new operation begins.
- **Back-to-back:** a start pulse in the cycle RDY is high is legal and gives a full new latency.
- **Multi-cycle start:** a start held high for N cycles restarts on every edge; the effective E0 is the last edge on which it was high.

## Test plan
- **Signed multiply:** A=7, B=-3, MULT pulse → `busy` high E0..E16, `data_result` = 0xFFFFFFEB, exception 0, RDY high only between E17 and E18.
- **Multiply overflow:** A=0x00010000, B=0x00010000 → result 0x00000000, exception 1 at E17. Then A=-1, B=-1 → result 1, exception 0.
- **Signed divide:**
  - A=-7, B=2 → result 0xFFFFFFFD, exception 0, RDY at E33.
  - A=0x80000000, B=-1 → result 0x80000000, exception 1.
- **Divide by zero:** A=5, B=0 → result 0, exception 1, RDY at E33, `busy` low from E33.
- **Restart and simultaneous start:**
  - DIV 100/7 started, MULT 6*7 pulsed at E10 → no RDY at the old E33. Result 42 with RDY 17 edges after E10.
  - MULT and DIV pulsed together with A=6, B=3 → result 18 at E17.
- **Asynchronous reset:** reset asserted mid-clock during MUL iteration 5 → all outputs 0 immediately without a clock edge. After release, no RDY pulse ever appears for the aborted operation.
